// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between decode, the execute ALU and writeback.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid, in_ready, out_valid, out_ready, illegal;
    logic [3:0]       op, flags;
    logic [WIDTH-1:0] a, b, result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU with registered result, {N,Z,C,V} flags and illegal flag.
// Define ALU_PIPE_MUL_EN to compile in the iterative shift-add multiplier for op 9.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0]   res, result_q, result_d;
    logic [WIDTH:0]     sum, diff;
    logic [SW-1:0]      sh;
    logic [3:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] mul_p;
    logic c, v, ill, is_mul, idle, accept, out_free, mul_load;
    logic out_valid_q, out_valid_d, illegal_q, illegal_d;

    assign sh           = bus.b[SW-1:0];
    assign sum          = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff         = {1'b0, bus.a} - {1'b0, bus.b};
    assign out_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = idle && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (bus.op)
            4'd0: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                res = diff[WIDTH-1:0];
                c   = !diff[WIDTH];
                v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2:    res = bus.a & bus.b;
            4'd3:    res = bus.a | bus.b;
            4'd4:    res = bus.a ^ bus.b;
            4'd5:    res = WIDTH'($signed(bus.a) < $signed(bus.b));
            4'd6:    res = bus.a << sh;
            4'd7:    res = bus.a >> sh;
            4'd8:    res = $unsigned($signed(bus.a) >>> sh);
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SW:0]        cnt_q, cnt_d;
    logic               last;

    assign is_mul    = bus.op == 4'd9;
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last      = cnt_q == (SW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (last) state_d = out_free ? S_IDLE : S_HOLD;
            S_HOLD:  if (out_free) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The final step's sum feeds the output register directly so the product lands on edge k+WIDTH.
    always_comb begin
        idle     = state_q == S_IDLE;
        mul_load = ((state_q == S_MUL && last) || state_q == S_HOLD) && out_free;
        mul_p    = (state_q == S_HOLD) ? prod_q : prod_step;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (state_q == S_IDLE && accept && is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            prod_d   = '0;
            cnt_d    = (SW+1)'(WIDTH);
        end else if (state_q == S_MUL) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - (SW+1)'(1);
        end
    end
`else
    assign is_mul   = 1'b0;
    assign idle     = 1'b1;
    assign mul_load = 1'b0;
    assign mul_p    = '0;
`endif

    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        if (accept && !is_mul) begin
            out_valid_d = 1'b1;
            result_d    = res;
            flags_d     = {res[WIDTH-1], res == '0, c, v};
            illegal_d   = ill;
        end else if (mul_load) begin
            out_valid_d = 1'b1;
            result_d    = mul_p[WIDTH-1:0];
            flags_d     = {mul_p[WIDTH-1], mul_p[WIDTH-1:0] == '0, |mul_p[2*WIDTH-1:WIDTH], 1'b0};
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8; expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8)) bus();
    alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_cmp = 0, n_err = 0, n_xfer = 0;
    logic [12:0] sbq[$];
    logic [12:0] mon_exp, prev;
    logic        hold_prev = 1'b0;

    // Independent reference: {result[7:0], N, Z, C, V, illegal}
    function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, full, r;
        logic c, v, il;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        c = 1'b0; v = 1'b0; il = 1'b0; r = 0; full = 0;
        case (o)
            4'd0: begin full = ux + uy; c = full > 255; v = (sx + sy > 127) || (sx + sy < -128); r = full % 256; end
            4'd1: begin c = ux >= uy; v = (sx - sy > 127) || (sx - sy < -128); r = (ux - uy + 256) % 256; end
            4'd2: r = ux & uy;
            4'd3: r = ux | uy;
            4'd4: r = ux ^ uy;
            4'd5: r = (sx < sy) ? 1 : 0;
            4'd6: r = (ux << (uy % 8)) % 256;
            4'd7: r = ux >> (uy % 8);
            4'd8: r = (sx >>> (uy % 8)) & 255;
`ifdef ALU_PIPE_MUL_EN
            4'd9: begin full = ux * uy; c = full > 255; r = full % 256; end
`endif
            default: il = 1'b1;
        endcase
        return {r[7:0], r[7], r == 0, c, v, il};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) hold_prev = 1'b0;
        else begin
            if (hold_prev) begin
                n_cmp++;
                if ({bus.result, bus.flags, bus.illegal} !== prev) begin
                    n_err++;
                    $display("FAIL stall_stability got=%h exp=%h", {bus.result, bus.flags, bus.illegal}, prev);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output got=%h exp=none", {bus.result, bus.flags, bus.illegal});
                end else begin
                    mon_exp = sbq.pop_front();
                    if ({bus.result, bus.flags, bus.illegal} !== mon_exp) begin
                        n_err++;
                        $display("FAIL scoreboard got=%h exp=%h", {bus.result, bus.flags, bus.illegal}, mon_exp);
                    end
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev = {bus.result, bus.flags, bus.illegal};
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int t = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            if (t >= 1) bus.out_ready = 1'b1;
            t++;
            @(negedge clk);
        end
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout got=in_ready_low exp=accept op=%0d", o);
        end else sbq.push_back(model(o, x, y));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        while ((sbq.size() != 0 || bus.out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sbq.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL reset_result got=%h exp=00", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_add();
        wait_drain();
        send(4'd0, 8'hFF, 8'h01);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL add_result got=%h exp=00", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_err++; $display("FAIL add_flags got=%b exp=0110", bus.flags); end
        send(4'd0, 8'h7F, 8'h01);
        @(negedge clk);
        n_cmp++; if (bus.flags !== 4'b1001) begin n_err++; $display("FAIL add_ovf_flags got=%b exp=1001", bus.flags); end
    endtask

    task automatic test_sub_slt();
        wait_drain();
        send(4'd1, 8'h80, 8'h01);
        @(negedge clk);
        n_cmp++; if (bus.result !== 8'h7F) begin n_err++; $display("FAIL sub_result got=%h exp=7f", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0011) begin n_err++; $display("FAIL sub_flags got=%b exp=0011", bus.flags); end
        send(4'd5, 8'hFE, 8'h01);
        @(negedge clk);
        n_cmp++; if (bus.result !== 8'h01) begin n_err++; $display("FAIL slt_result got=%h exp=01", bus.result); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        wait_drain();
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            bus.in_valid = 1'b1; bus.op = 4'(i); bus.a = x; bus.b = y;
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1 op=%0d", bus.in_ready, i); end
            else sbq.push_back(model(4'(i), x, y));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        wait_drain();
        bus.out_ready = 1'b0;
        send(4'd0, 8'h02, 8'h03);
        bus.in_valid = 1'b1; bus.op = 4'd4; bus.a = 8'h5A; bus.b = 8'h0F;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
            n_cmp++; if (bus.result !== 8'h05) begin n_err++; $display("FAIL bp_result got=%h exp=05", bus.result); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        else sbq.push_back(model(4'd4, 8'h5A, 8'h0F));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_xor_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.result !== 8'h55) begin n_err++; $display("FAIL bp_xor_result got=%h exp=55", bus.result); end
    endtask

    task automatic test_mul();
        int cnt = 0;
        wait_drain();
`ifdef ALU_PIPE_MUL_EN
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 8'd13; bus.b = 8'd11;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mul_accept got=%b exp=1", bus.in_ready); end
        else sbq.push_back(model(4'd9, 8'd13, 8'd11));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        while (!bus.in_ready && cnt < 50) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != 8) begin n_err++; $display("FAIL mul_busy_cycles got=%0d exp=8", cnt); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mul_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.result !== 8'h8F) begin n_err++; $display("FAIL mul_result got=%h exp=8f", bus.result); end
        n_cmp++; if (bus.flags !== 4'b1000) begin n_err++; $display("FAIL mul_flags got=%b exp=1000", bus.flags); end
        send(4'd9, 8'h10, 8'h10);
        cnt = 0;
        @(negedge clk);
        while (!bus.out_valid && cnt < 50) begin cnt++; @(negedge clk); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL mul_wrap_result got=%h exp=00", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_err++; $display("FAIL mul_wrap_flags got=%b exp=0110", bus.flags); end
`else
        send(4'd9, 8'd13, 8'd11);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mul_off_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL mul_off_illegal got=%b exp=1", bus.illegal); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL mul_off_result got=%h exp=00", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0100) begin n_err++; $display("FAIL mul_off_flags got=%b exp=0100", bus.flags); end
`endif
    endtask

    task automatic test_illegal();
        wait_drain();
        send(4'hF, 8'h12, 8'h34);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", bus.illegal); end
        n_cmp++; if (bus.result !== 8'h00) begin n_err++; $display("FAIL ill_result got=%h exp=00", bus.result); end
        n_cmp++; if (bus.flags !== 4'b0100) begin n_err++; $display("FAIL ill_flags got=%b exp=0100", bus.flags); end
    endtask

    task automatic test_random();
        wait_drain();
        for (int i = 0; i < 60; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid_op();
        int x0;
        wait_drain();
`ifdef ALU_PIPE_MUL_EN
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 8'h77; bus.b = 8'h55;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mul_accept got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
`else
        bus.out_ready = 1'b0;
        send(4'd0, 8'h11, 8'h22);
        @(posedge clk);
`endif
        #1 rst_n = 1'b0;
        #1;
        sbq.delete();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        x0 = n_xfer;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
        repeat (12) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (n_xfer != x0) begin n_err++; $display("FAIL rst_mid_transfers got=%0d exp=%0d", n_xfer, x0); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_back_to_back();
        test_backpressure();
        test_mul();
        test_illegal();
        test_random();
        test_reset_mid_op();
        wait_drain();
        n_cmp++;
        if (sbq.size() != 0) begin n_err++; $display("FAIL final_queue got=%0d exp=0", sbq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
